if_fetch_resp: RTL
==================

Name: if_fetch_resp

Overview:
- IF-stage fetch responder on the far side of the PC stage's fetch request (read_req / pc_next).
- Captures each requested PC, runs one memory read (address then data handshake), and selects the 32-bit instruction lane.
- Presents {inst, pc, valid, fault} to the IF/ID boundary.
- Raises a stall request toward the controller while a fetch is outstanding; honours IF stall and flush.

Parameters:
- XLEN, 64, address/PC width.
- DATA_W, 64, memory read data width; must be 64 (lane select uses pc[2]).
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- read_req_i  in  1  fetch request from PC stage
- pc_next_i  in  XLEN  fetch address
- stall_i  in  1  IF-stage stall bit from controller stall bus
- flush_i  in  1  IF-stage flush bit from controller flush bus
- mem_ar_valid_o  out  1  read address valid
- mem_ar_ready_i  in  1  read address ready
- mem_ar_addr_o  out  XLEN  read address, 8-byte aligned
- mem_r_valid_i  in  1  read data valid
- mem_r_ready_o  out  1  read data ready
- mem_r_data_i  in  DATA_W  read data
- mem_r_err_i  in  1  bus error on read
- inst_o  out  INST_W  fetched instruction
- inst_pc_o  out  XLEN  PC of inst_o
- inst_valid_o  out  1  inst_o valid
- inst_fault_o  out  1  access fault (bus error or misaligned)
- stall_req_o  out  1  stall request to controller

Behaviour:
- Reset values: all outputs 0; state IDLE; drop flag 0; internal pc register 0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - read_req_i & ~stall_i & ~flush_i & pc_next_i[1:0]==0: latch pc_next_i, go REQ.
  - Same conditions but pc_next_i[1:0]!=0: latch PC, set fault, inst=0, go HOLD. No bus transaction.
  - Otherwise stay in IDLE.
- REQ:
  - mem_ar_valid_o=1, mem_ar_addr_o={pc[XLEN-1:3],3'b0}.
  - Valid and address stay stable until mem_ar_ready_i; then go WAIT.
- WAIT:
  - mem_r_ready_o=1.
  - On mem_r_valid_i with drop=0: latch inst = pc[2] ? data[63:32] : data[31:0], latch fault=mem_r_err_i, go HOLD.
  - On mem_r_valid_i with drop=1: discard beat, clear drop, go IDLE.
- HOLD:
  - inst_valid_o=1.
  - Consumed on any cycle with ~stall_i. If read_req_i (not flush) is also present that cycle, capture the new PC and go REQ (or HOLD if misaligned); else go IDLE.
  - While stall_i=1, outputs hold unchanged.
- stall_req_o = (state==REQ) | (state==WAIT).
- Flush:
  - IDLE: the request that cycle is ignored.
  - REQ: ar_valid is not retracted (protocol rule); set drop and finish the transaction.
  - WAIT: set drop; if r_valid arrives the same cycle, discard it and go IDLE.
  - HOLD: go IDLE; inst_valid_o=0 next cycle.
- Flush and stall in the same cycle: flush wins.
- Minimum latency, request accepted in cycle 0 with zero-wait memory: REQ cycle 1, WAIT cycle 2, inst_valid_o cycle 3.
- Only one outstanding transaction; no new address is issued until the data beat is received.
- inst_fault_o is valid only with inst_valid_o; inst_o=0 when fault.
- Reset asserted mid-transaction: FSM returns to IDLE immediately, outputs cleared. The memory side is reset on the same rst.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - In WAIT with mem_r_valid_i & ~drop & ~stall_i, the lane-selected data drives inst_o/inst_fault_o combinationally with inst_valid_o=1 that cycle.
  - HOLD is skipped: next state is REQ if a new request is captured, else IDLE.
  - With stall_i=1, behaviour is as without the macro (latch into HOLD).
  - Saves one cycle: minimum latency is 2.
- Not defined: all outputs come from registers; latency is 3.

Decomposition:
- sysconfig.v holds: XLEN/XLEN_BUS, INST_W, CTRLBUS_IF index, FSM state encodings (2-bit localparam-style defines), NOP/zero instruction constant.
- Captured PC, instruction and fault registers instantiate the existing regTemplate (RESET_VAL 0). No new sub-module.

Test Plan:
- Single fetch, zero-wait: read_req_i=1, pc_next_i=0x8000_0004, ar_ready=1, data 0x00A0_0093_0000_0013 -> ar_addr=0x8000_0000; cycle 3 inst_o=0x00A00093, inst_pc_o=0x8000_0004, valid=1; stall_req_o=1 in cycles 1-2 only.
- Backpressure: ar_ready low 3 cycles, r_valid 2 cycles late, pc=0x8000_0000 -> ar_valid/addr stable throughout; inst_o=low word; stall_req_o high for the whole wait.
- Flush in WAIT: flush_i pulse the cycle after ar handshake, then r_valid -> no inst_valid_o; state IDLE; next request at 0x8000_0000 fetches normally.
- Stall in HOLD: stall_i=1 for 4 cycles with valid instruction -> inst_o/pc/valid constant; releases on the first ~stall cycle and back-to-back captures a pending read_req.
- Errors: mem_r_err_i=1 on the beat -> inst_fault_o=1, inst_o=0. pc_next_i=0x8000_0002 -> fault=1, no ar_valid ever asserted.
- Async reset asserted while in REQ -> all outputs 0 immediately, before the next clk edge; FSM IDLE.

Source files
------------

// File: rtl/if_fetch_resp_pkg.sv
// Shared configuration for the IF fetch responder: widths, FSM encodings,
// the zero instruction used on faults, and the 64-bit lane selector.
package if_fetch_resp_pkg;

    localparam int P_XLEN   = 64;
    localparam int P_DATA_W = 64;
    localparam int P_INST_W = 32;

    // FSM encodings, kept as plain 2-bit constants for legacy consumers
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Instruction value presented alongside any access fault
    localparam logic [P_INST_W-1:0] INST_ZERO = '0;

    // Pick the 32-bit instruction out of an 8-byte beat using pc[2]
    function automatic logic [P_INST_W-1:0] lane_sel(input logic sel_hi,
                                                     input logic [P_DATA_W-1:0] data);
        return sel_hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/if_fetch_resp_reg.sv
// Enabled register with asynchronous active-high reset to RESET_VAL.
// Holds the captured PC, instruction and fault of the fetch responder.
module if_fetch_resp_reg #(
    parameter int             W         = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Load d_i when enabled, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/if_fetch_resp.sv
// IF-stage fetch responder: captures the requested PC, performs one memory
// read (address then data handshake), selects the instruction lane and holds
// {inst, pc, valid, fault} for the IF/ID boundary.
// Optional macro FETCH_BYPASS_EN: forwards an unstalled read beat straight to
// the outputs in the same cycle, skipping HOLD.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; mem_ar_valid_o and mem_ar_addr_o stay stable until mem_ar_ready_i, and
// a flush never retracts an address already offered (the beat is dropped later).
module if_fetch_resp
    import if_fetch_resp_pkg::*;
#(
    parameter int XLEN   = P_XLEN,
    parameter int DATA_W = P_DATA_W,
    parameter int INST_W = P_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_req_i,
    input  logic [XLEN-1:0]   pc_next_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              mem_ar_valid_o,
    input  logic              mem_ar_ready_i,
    output logic [XLEN-1:0]   mem_ar_addr_o,
    input  logic              mem_r_valid_i,
    output logic              mem_r_ready_o,
    input  logic [DATA_W-1:0] mem_r_data_i,
    input  logic              mem_r_err_i,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   inst_pc_o,
    output logic              inst_valid_o,
    output logic              inst_fault_o,
    output logic              stall_req_o,
    output logic [1:0]        dbg_state_o
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_d;
    logic              r_drop;
    logic              w_drop_d;
    logic              w_capture;
    logic              w_pc_en;
    logic [XLEN-1:0]   r_pc;
    logic              w_inst_en;
    logic [INST_W-1:0] w_inst_d;
    logic [INST_W-1:0] r_inst;
    logic              w_fault_d;
    logic              r_fault;
    logic              w_bypass;
    logic              w_take;
    logic              w_misal;
    logic [INST_W-1:0] w_beat_inst;

    assign w_take      = read_req_i & ~stall_i & ~flush_i;
    assign w_misal     = |pc_next_i[1:0];
    // A bus error returns the zero instruction, never the erroneous data
    assign w_beat_inst = mem_r_err_i ? INST_ZERO : lane_sel(r_pc[2], mem_r_data_i);

    // Next-state, drop flag and register-load decisions
    always_comb begin
        w_state_d = r_state;
        w_drop_d  = r_drop;
        w_capture = 1'b0;
        w_pc_en   = 1'b0;
        w_inst_en = 1'b0;
        w_inst_d  = w_beat_inst;
        w_fault_d = mem_r_err_i;
        w_bypass  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_capture = w_take;
            end
            ST_REQ: begin
                if (flush_i) w_drop_d = 1'b1;
                if (mem_ar_ready_i) w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_r_valid_i) begin
                    if (r_drop | flush_i) begin
                        w_drop_d  = 1'b0;
                        w_state_d = ST_IDLE;
                    end
`ifdef FETCH_BYPASS_EN
                    else if (!stall_i) begin
                        w_bypass  = 1'b1;
                        w_state_d = ST_IDLE;
                        w_capture = read_req_i;
                    end
`endif
                    else begin
                        w_inst_en = 1'b1;
                        w_state_d = ST_HOLD;
                    end
                end else if (flush_i) begin
                    w_drop_d = 1'b1;
                end
            end
            default: begin // ST_HOLD
                if (flush_i) begin
                    w_state_d = ST_IDLE;
                end else if (!stall_i) begin
                    w_state_d = ST_IDLE;
                    w_capture = read_req_i;
                end
            end
        endcase
        // New PC accepted: aligned goes to the bus, misaligned faults locally
        if (w_capture) begin
            w_pc_en = 1'b1;
            if (w_misal) begin
                w_inst_en = 1'b1;
                w_inst_d  = INST_ZERO;
                w_fault_d = 1'b1;
                w_state_d = ST_HOLD;
            end else begin
                w_state_d = ST_REQ;
            end
        end
    end

    // FSM state and pending-drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_drop  <= w_drop_d;
        end
    end

    if_fetch_resp_reg #(.W(XLEN), .RESET_VAL('0)) u_pc_reg (
        .clk(clk), .rst(rst), .en_i(w_pc_en), .d_i(pc_next_i), .q_o(r_pc)
    );

    if_fetch_resp_reg #(.W(INST_W), .RESET_VAL('0)) u_inst_reg (
        .clk(clk), .rst(rst), .en_i(w_inst_en), .d_i(w_inst_d), .q_o(r_inst)
    );

    if_fetch_resp_reg #(.W(1), .RESET_VAL(1'b0)) u_fault_reg (
        .clk(clk), .rst(rst), .en_i(w_inst_en), .d_i(w_fault_d), .q_o(r_fault)
    );

    assign mem_ar_valid_o = (r_state == ST_REQ);
    assign mem_ar_addr_o  = {r_pc[XLEN-1:3], 3'b000};
    assign mem_r_ready_o  = (r_state == ST_WAIT);
    assign stall_req_o    = (r_state == ST_REQ) | (r_state == ST_WAIT);
    assign inst_valid_o   = (r_state == ST_HOLD) | w_bypass;
    assign inst_o         = w_bypass ? w_beat_inst : r_inst;
    assign inst_fault_o   = w_bypass ? mem_r_err_i : ((r_state == ST_HOLD) & r_fault);
    assign inst_pc_o      = r_pc;
    assign dbg_state_o    = r_state;

endmodule
